mem_port_arbiter: RTL and testbench

- Shares the single synchronous memory/IO port (20-bit word address, 32-bit data) between two requesters.
- Requester 0 is the CPU core. Requester 1 is a secondary master, such as a program loader or display/DMA engine.
- Serialises the requests, drives the memory port, enforces the fixed memory read latency and returns read data with a valid pulse.
- Sits between the CPU's memory interface and the memory block / IO decode.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait
    } arb_state_e;

    // Requester IDs, also used as bit indices into req/gnt/rvalid vectors.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_DATA_W = 32;

    // Width of the read-latency wait counter.
    function automatic int unsigned cnt_width(input int unsigned rd_lat);
        return $clog2(rd_lat + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the two requesters.
// MEM_ARB_RR_EN: round-robin on simultaneous requests; otherwise fixed priority, CPU first.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       any,
    output logic       winner
);

    // Pick a winner among the currently asserted requests.
    always_comb begin
        any = |req;
`ifdef MEM_ARB_RR_EN
        if (&req) begin
            winner = ~last_grant;
        end else begin
            winner = req[REQ_CPU] ? REQ_CPU : REQ_AUX;
        end
`else
        winner = req[REQ_CPU] ? REQ_CPU : REQ_AUX;
`endif
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority keeps last_grant tracked upstream but does not consult it.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between the CPU (m0) and an auxiliary master (m1).
// Serialises requests, enforces the fixed read latency and returns read data with a pulse.
// MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_pick).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_write_value,
    input  logic [DATA_W-1:0] mem_read_value,
    output logic              busy
);

    localparam int unsigned      CNT_W    = cnt_width(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              win_q, win_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              capture;

    logic              pick_any;
    logic              pick_winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    mem_arb_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .any        (pick_any),
        .winner     (pick_winner)
    );

    // Route the winning requester's command towards the port registers.
    always_comb begin
        sel_we    = pick_winner ? m1_we    : m0_we;
        sel_addr  = pick_winner ? m1_addr  : m0_addr;
        sel_wdata = pick_winner ? m1_wdata : m0_wdata;
    end

    // Next-state and registered-output logic for the IDLE/ACCESS/WAIT sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = 1'b0;
        wdata_d      = wdata_q;
        gnt_d        = '0;
        rvalid_d     = '0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        capture      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    win_d              = pick_winner;
                    last_grant_d       = pick_winner;
                    gnt_d[pick_winner] = 1'b1;
                    addr_d             = sel_addr;
                    we_d               = sel_we;
                    if (sel_we) begin
                        wdata_d = sel_wdata;
                    end
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (we_q) begin
                    state_d = StIdle;
                end else if (RD_LAT == 1) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Capture on the cycle the decremented count reaches zero.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            rvalid_d[win_q] = 1'b1;
            unique case (win_q)
                REQ_CPU: rdata0_d = mem_read_value;
                REQ_AUX: rdata1_d = mem_read_value;
            endcase
        end
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            win_q        <= REQ_CPU;
            last_grant_q <= REQ_AUX;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            gnt_q        <= '0;
            rvalid_q     <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign m0_gnt           = gnt_q[REQ_CPU];
    assign m1_gnt           = gnt_q[REQ_AUX];
    assign m0_rvalid        = rvalid_q[REQ_CPU];
    assign m1_rvalid        = rvalid_q[REQ_AUX];
    assign m0_rdata         = rdata0_q;
    assign m1_rdata         = rdata1_q;
    assign mem_address      = addr_q;
    assign mem_write_enable = we_q;
    assign mem_write_value  = wdata_q;
    assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked cycle by cycle against a timeline-based reference model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m1_req = 1'b0, m1_we = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_write_value, mem_read_value;
    logic              busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .m0_req           (m0_req),
        .m0_we            (m0_we),
        .m0_addr          (m0_addr),
        .m0_wdata         (m0_wdata),
        .m0_gnt           (m0_gnt),
        .m0_rvalid        (m0_rvalid),
        .m0_rdata         (m0_rdata),
        .m1_req           (m1_req),
        .m1_we            (m1_we),
        .m1_addr          (m1_addr),
        .m1_wdata         (m1_wdata),
        .m1_gnt           (m1_gnt),
        .m1_rvalid        (m1_rvalid),
        .m1_rdata         (m1_rdata),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_value  (mem_write_value),
        .mem_read_value   (mem_read_value),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEADBEEF;
        return 32'(i) * 32'h9E3779B1;
    endfunction

    // ---------------- memory environment: data valid RD_LAT edges after address --------------
    logic [31:0] mem [0:4095];
    logic [31:0] rd_pipe [0:7];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
        forever begin
            @(posedge clk);
            rd_pipe[0] <= mem[mem_address[11:0]];
            for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
            if (mem_write_enable === 1'b1) mem[mem_address[11:0]] <= mem_write_value;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign mem_read_value = mem[mem_address[11:0]];
        end else begin : g_latn
            assign mem_read_value = rd_pipe[RD_LAT-2];
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: transaction timeline arithmetic ----------------
    logic [31:0] ref_mem [0:4095];
    int          cyc = 0, next_free = 0, rv_cycle = -1;
    bit          rv_who, e_last = 1'b1, mon_on = 1'b0;
    logic [31:0] rv_data;
    logic [1:0]  e_gnt = '0, e_rv = '0;
    logic        e_we = 1'b0, e_busy = 1'b0;
    logic [19:0] e_addr = '0;
    logic [31:0] e_wval = '0, e_rd0 = '0, e_rd1 = '0;

    function automatic bit pick(input bit r0, input bit r1, input bit last);
        bit rr;
        rr = 1'b0;
`ifdef MEM_ARB_RR_EN
        rr = 1'b1;
`endif
        if (rr && r0 && r1) return !last;
        return r0 ? 1'b0 : 1'b1;
    endfunction

    initial begin
        bit          w;
        logic        t_we;
        logic [19:0] t_a;
        logic [31:0] t_d;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            e_gnt = '0;
            e_rv  = '0;
            e_we  = 1'b0;
            if (rst) begin
                mon_on    = 1'b1;
                next_free = cyc + 1;
                rv_cycle  = -1;
                e_addr    = '0;
                e_wval    = '0;
                e_rd0     = '0;
                e_rd1     = '0;
                e_last    = 1'b1;
            end else begin
                if (rv_cycle == cyc) begin
                    e_rv[rv_who] = 1'b1;
                    if (rv_who) e_rd1 = rv_data;
                    else        e_rd0 = rv_data;
                    rv_cycle = -1;
                end
                if (cyc >= next_free && (m0_req || m1_req)) begin
                    w        = pick(m0_req, m1_req, e_last);
                    t_we     = w ? m1_we : m0_we;
                    t_a      = w ? m1_addr : m0_addr;
                    t_d      = w ? m1_wdata : m0_wdata;
                    e_gnt[w] = 1'b1;
                    e_last   = w;
                    e_addr   = t_a;
                    if (t_we) begin
                        e_we               = 1'b1;
                        e_wval             = t_d;
                        ref_mem[t_a[11:0]] = t_d;
                        next_free          = cyc + 2;
                    end else begin
                        rv_cycle  = cyc + RD_LAT;
                        rv_who    = w;
                        rv_data   = ref_mem[t_a[11:0]];
                        next_free = cyc + RD_LAT + 1;
                    end
                end
            end
            e_busy = (cyc < next_free - 1);
            cyc++;
        end
    end

    // Compare every DUT output against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("mon_gnt", 32'({m1_gnt, m0_gnt}), 32'(e_gnt));
                chk("mon_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'(e_rv));
                chk("mon_rdata0", m0_rdata, e_rd0);
                chk("mon_rdata1", m1_rdata, e_rd1);
                chk("mon_addr", 32'(mem_address), 32'(e_addr));
                chk("mon_we", 32'(mem_write_enable), 32'(e_we));
                chk("mon_wval", mem_write_value, e_wval);
                chk("mon_busy", 32'(busy), 32'(e_busy));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        bit          port;
        bit          we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [7];

    function automatic logic gnt_of(input bit p);
        return p ? m1_gnt : m0_gnt;
    endfunction

    function automatic logic rvalid_of(input bit p);
        return p ? m1_rvalid : m0_rvalid;
    endfunction

    function automatic logic [31:0] rdata_of(input bit p);
        return p ? m1_rdata : m0_rdata;
    endfunction

    task automatic set_req(input bit p, input logic r, input logic we, input logic [19:0] a,
                           input logic [31:0] d);
        if (p) begin
            m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'({m1_gnt, m0_gnt}), 32'd0);
        chk({tag, "_rvalid"}, 32'({m1_rvalid, m0_rvalid}), 32'd0);
        chk({tag, "_rdata0"}, m0_rdata, 32'd0);
        chk({tag, "_rdata1"}, m1_rdata, 32'd0);
        chk({tag, "_addr"}, 32'(mem_address), 32'd0);
        chk({tag, "_we"}, 32'(mem_write_enable), 32'd0);
        chk({tag, "_wval"}, mem_write_value, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // One transaction from idle with fixed expectations.
    task automatic run_txn(input vec_t v);
        int n;
        set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt_of(v.port) && n < 20);
        chk("txn_gnt_delay", 32'(n), 32'd1);
        chk("txn_addr", 32'(mem_address), 32'(v.addr));
        chk("txn_we", 32'(mem_write_enable), 32'(v.we));
        chk("txn_busy", 32'(busy), 32'd1);
        set_req(v.port, 1'b0, v.we, v.addr, v.wdata);
        if (v.we) begin
            chk("txn_wval", mem_write_value, v.wdata);
            @(negedge clk);
            chk("txn_we_drop", 32'(mem_write_enable), 32'd0);
            chk("txn_busy_drop", 32'(busy), 32'd0);
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                chk("txn_rd_no_we", 32'(mem_write_enable), 32'd0);
            end while (!rvalid_of(v.port) && n < 20);
            chk("txn_rd_lat", 32'(n), 32'(RD_LAT));
            chk("txn_rdata", rdata_of(v.port), v.rdata);
            chk("txn_rd_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_req(input bit p);
        logic r, g;
        r = p ? m1_req : m0_req;
        g = p ? m1_gnt : m0_gnt;
        if (r && g) r = 1'b0;
        else if (r && $urandom_range(0, 15) == 0) r = 1'b0;
        if (!r) begin
            set_req(p, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    20'($urandom_range(0, 4095)), $urandom());
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, extra, seen, rv_at;
        int order[$];
        int exp4 [4];
        int first, second;

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 20'h00010, wdata: 32'h0, rdata: 32'hDEADBEEF};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 20'h00F00, wdata: 32'h12345678, rdata: 32'h0};
        vecs[2] = '{port: 1'b0, we: 1'b0, addr: 20'h00F00, wdata: 32'h0, rdata: 32'h12345678};
        vecs[3] = '{port: 1'b1, we: 1'b0, addr: 20'h00010, wdata: 32'h0, rdata: 32'hDEADBEEF};
        vecs[4] = '{port: 1'b0, we: 1'b1, addr: 20'h00010, wdata: 32'hCAFEF00D, rdata: 32'h0};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 20'h00010, wdata: 32'h0, rdata: 32'hCAFEF00D};
        vecs[6] = '{port: 1'b1, we: 1'b0, addr: 20'h00F00, wdata: 32'h0, rdata: 32'h12345678};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Simultaneous requests from a fresh reset: m0 first, m1 next.
        do_reset();
        set_req(1'b0, 1'b1, 1'b1, 20'h00100, 32'h11110000);
        set_req(1'b1, 1'b1, 1'b1, 20'h00101, 32'h22220000);
        order.delete();
        for (int c = 0; c < 20 && order.size() < 2; c++) begin
            @(negedge clk);
            if (m0_gnt) begin order.push_back(0); m0_req = 1'b0; end
            if (m1_gnt) begin order.push_back(1); m1_req = 1'b0; end
        end
        first  = (order.size() > 0) ? order[0] : 9;
        second = (order.size() > 1) ? order[1] : 9;
        chk("pair_first", 32'(first), 32'd0);
        chk("pair_second", 32'(second), 32'd1);

        // Four rounds of continuous contention.
`ifdef MEM_ARB_RR_EN
        exp4 = '{0, 1, 0, 1};
`else
        exp4 = '{0, 0, 0, 0};
`endif
        set_req(1'b0, 1'b1, 1'b1, 20'h00200, 32'h33330000);
        set_req(1'b1, 1'b1, 1'b1, 20'h00201, 32'h44440000);
        order.delete();
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            if (m0_gnt) order.push_back(0);
            if (m1_gnt) order.push_back(1);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            first = (order.size() > i) ? order[i] : 9;
            chk("round_grant", 32'(first), 32'(exp4[i]));
        end
        repeat (3) @(negedge clk);

        // m0 drops req and changes its command while the read is in flight.
        set_req(1'b0, 1'b1, 1'b0, 20'h00F00, 32'h0);
        n = 0;
        do begin @(negedge clk); n++; end while (!m0_gnt && n < 20);
        chk("wd_gnt_delay", 32'(n), 32'd1);
        set_req(1'b0, 1'b0, 1'b1, 20'h00010, 32'hBADBAD00);
        extra = 0; seen = 0; rv_at = 0;
        for (int c = 1; c <= int'(RD_LAT) + 3; c++) begin
            @(negedge clk);
            if (m0_gnt) extra++;
            if (m0_rvalid) begin
                seen++;
                rv_at = c;
                chk("wd_rdata", m0_rdata, 32'h12345678);
            end
        end
        chk("wd_extra_gnt", 32'(extra), 32'd0);
        chk("wd_rv_count", 32'(seen), 32'd1);
        chk("wd_rv_lat", 32'(rv_at), 32'(RD_LAT));

        // Reset while a read is pending: no rvalid afterwards.
        set_req(1'b0, 1'b1, 1'b0, 20'h00010, 32'h0);
        n = 0;
        do begin @(negedge clk); n++; end while (!m0_gnt && n < 20);
        m0_req = 1'b0;
        if (RD_LAT > 1) @(negedge clk);
        chk("rw_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rw");
        seen = 0;
        for (int c = 0; c < int'(RD_LAT) + 2; c++) begin
            @(negedge clk);
            if (m0_rvalid || m1_rvalid) seen++;
        end
        chk("rw_no_rvalid", 32'(seen), 32'd0);

        // Randomized traffic with occasional resets, checked by the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 249) == 0);
            rand_req(1'b0);
            rand_req(1'b1);
        end
        rst    = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (RD_LAT + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
